// File: rtl/als_scheduler.sv
// Periodic ALS conversion scheduler: requests a conversion every PERIOD_CYCLES,
// waits for completion with a timeout, and publishes the (optionally averaged) value.
// Optional feature: define ALS_AVERAGE_EN for a 4-sample moving-average output.
module als_scheduler #(
  parameter int unsigned PERIOD_CYCLES  = 1200000,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       i_system_clock,
  input  logic       i_aresetn,
  input  logic       i_enable,
  input  logic       i_clear,
  output logic       o_start,
  input  logic       i_done,
  input  logic [7:0] i_sample,
  output logic [7:0] o_value,
  output logic       o_valid,
  output logic       o_timeout
);

  localparam int unsigned PW = (PERIOD_CYCLES  > 1) ? $clog2(PERIOD_CYCLES)  : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PERIOD_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, UPDATE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] period_q, period_d;
  logic [TW-1:0] to_q, to_d;
  logic          timeout_q, timeout_d;
  logic [7:0]    value_q, value_d;
  logic          tick;
  logic          capture;

  always_comb begin
    period_d = period_q;
    tick     = 1'b0;
    if (!i_enable) begin
      period_d = '0;
    end else if (period_q == P_LAST) begin
      period_d = '0;
      tick     = 1'b1;
    end else begin
      period_d = period_q + PW'(1);
    end
  end

  // Ticks arriving outside IDLE are simply dropped; i_done beats the timeout.
  always_comb begin
    state_d   = state_q;
    to_d      = to_q;
    timeout_d = timeout_q;
    capture   = 1'b0;
    if (i_clear) timeout_d = 1'b0;
    case (state_q)
      IDLE:   if (tick) state_d = START;
      START: begin
        to_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (i_done) begin
          capture = 1'b1;
          state_d = UPDATE;
        end else if (to_q == T_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      UPDATE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign o_start   = (state_q == START);
  assign o_valid   = (state_q == UPDATE);
  assign o_value   = value_q;
  assign o_timeout = timeout_q;

`ifdef ALS_AVERAGE_EN
  logic [3:0][7:0] win_q, win_d;
  logic [9:0]      sum_q, sum_d;
  logic            filled_q, filled_d;

  // First sample after reset seeds the whole window so the average starts at that sample.
  always_comb begin
    win_d    = win_q;
    sum_d    = sum_q;
    filled_d = filled_q;
    value_d  = value_q;
    if (capture) begin
      if (!filled_q) begin
        win_d    = {4{i_sample}};
        sum_d    = {i_sample, 2'b00};
        filled_d = 1'b1;
      end else begin
        win_d = {win_q[2:0], i_sample};
        sum_d = sum_q - {2'b00, win_q[3]} + {2'b00, i_sample};
      end
      value_d = sum_d[9:2];
    end
  end

  always_ff @(posedge i_system_clock or negedge i_aresetn) begin
    if (!i_aresetn) begin
      win_q    <= '0;
      sum_q    <= '0;
      filled_q <= 1'b0;
    end else begin
      win_q    <= win_d;
      sum_q    <= sum_d;
      filled_q <= filled_d;
    end
  end
`else
  always_comb begin
    value_d = value_q;
    if (capture) value_d = i_sample;
  end
`endif

  always_ff @(posedge i_system_clock or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_q   <= IDLE;
      period_q  <= '0;
      to_q      <= '0;
      timeout_q <= 1'b0;
      value_q   <= '0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      to_q      <= to_d;
      timeout_q <= timeout_d;
      value_q   <= value_d;
    end
  end

endmodule

// File: tb/tb_als_scheduler.sv
// Directed self-checking bench for als_scheduler (PERIOD_CYCLES=16, TIMEOUT_CYCLES=8).
// Expected values follow ALS_AVERAGE_EN when that macro is defined for the build.
module tb_als_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       clear;
  logic       start;
  logic       done;
  logic [7:0] sample;
  logic [7:0] value;
  logic       valid;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  als_scheduler #(
    .PERIOD_CYCLES (16),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .i_system_clock(clk),
    .i_aresetn     (rst_n),
    .i_enable      (enable),
    .i_clear       (clear),
    .o_start       (start),
    .i_done        (done),
    .i_sample      (sample),
    .o_value       (value),
    .o_valid       (valid),
    .o_timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Waits up to 40 cycles for o_start; reports -1 when it never comes.
  task automatic wait_start(input string tag, input int exp_gap);
    int n = 0;
    bit found = 0;
    while (n < 40 && !found) begin
      step();
      n++;
      if (start === 1'b1) found = 1;
    end
    chk(tag, found ? n : -1, exp_gap);
  endtask

  // Conversion with i_done three cycles after o_start; consumes 5 cycles after o_start.
  task automatic do_conv(input string tag, input int gap, input logic [7:0] s, input logic [7:0] expv);
    wait_start({tag, "_gap"}, gap);
    step();
    chk({tag, "_start_1cyc"}, start, 1'b0);
    step();
    step();
    done = 1'b1;
    sample = s;
    chk({tag, "_valid_pre"}, valid, 1'b0);
    step();
    done = 1'b0;
    sample = 8'h00;
    chk({tag, "_valid"}, valid, 1'b1);
    chk({tag, "_value"}, value, expv);
    step();
    chk({tag, "_valid_off"}, valid, 1'b0);
  endtask

  logic [7:0] seq_s [5] = '{8'h40, 8'h80, 8'h80, 8'h80, 8'h80};
`ifdef ALS_AVERAGE_EN
  logic [7:0] seq_e [5] = '{8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
  localparam logic [7:0] EXP_C = 8'h45;
`else
  logic [7:0] seq_e [5] = '{8'h40, 8'h80, 8'h80, 8'h80, 8'h80};
  localparam logic [7:0] EXP_C = 8'h55;
`endif

  initial begin
    rst_n = 1'b0; enable = 1'b0; clear = 1'b0; done = 1'b0; sample = 8'h00;
    repeat (3) step();
    chk("rst_start", start, 1'b0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_value", value, 8'h00);
    chk("rst_timeout", timeout, 1'b0);
    rst_n = 1'b1;
    enable = 1'b1;

    do_conv("a1", 16, 8'h40, 8'h40);
    do_conv("a2", 11, 8'h40, 8'h40);

    // Timeout: no done, flag after 8 WAIT cycles
    wait_start("b_gap", 11);
    repeat (8) step();
    chk("b_timeout_pre", timeout, 1'b0);
    step();
    chk("b_timeout", timeout, 1'b1);
    chk("b_value_kept", value, 8'h40);
    chk("b_valid", valid, 1'b0);
    do_conv("b2", 7, 8'h40, 8'h40);
    chk("b_timeout_sticky", timeout, 1'b1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("b_cleared", timeout, 1'b0);

    // Done on the final WAIT cycle wins over timeout
    wait_start("c_gap", 10);
    repeat (8) step();
    done = 1'b1;
    sample = 8'h55;
    chk("c_valid_pre", valid, 1'b0);
    step();
    done = 1'b0;
    sample = 8'h00;
    chk("c_valid", valid, 1'b1);
    chk("c_value", value, EXP_C);
    step();
    chk("c_timeout", timeout, 1'b0);

    // Reset during WAIT, late done ignored
    wait_start("d_gap", 6);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("d_rst_start", start, 1'b0);
    chk("d_rst_value", value, 8'h00);
    chk("d_rst_timeout", timeout, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    step();
    done = 1'b1;
    sample = 8'h99;
    step();
    done = 1'b0;
    sample = 8'h00;
    chk("d_late_valid", valid, 1'b0);
    chk("d_late_value", value, 8'h00);
    step();
    chk("d_late_valid2", valid, 1'b0);
    wait_start("d_restart_gap", 12);

    // Enable dropped mid-conversion
    step();
    enable = 1'b0;
    step();
    step();
    done = 1'b1;
    sample = 8'h22;
    step();
    done = 1'b0;
    sample = 8'h00;
    chk("e_valid", valid, 1'b1);
    chk("e_value", value, 8'h22);
    wait_start("e_no_start", -1);

    // Sample sequence from a fresh reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 5; i++)
      do_conv($sformatf("f%0d", i), (i == 0) ? 16 : 11, seq_s[i], seq_e[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
